// File: rtl/cpu_pkg.sv
// Shared constants for the accumulator CPU: opcodes, ALU op codes,
// jump conditions and the control_unit state encoding.
package cpu_pkg;

  localparam int unsigned OPC_W    = 4;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned COND_W   = 2;
  localparam int unsigned STATE_W  = 3;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_STA = 4'h4;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h5;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h6;
  localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_PASS = 3'b010;

  localparam logic [COND_W-1:0] COND_ALWAYS = 2'd0;
  localparam logic [COND_W-1:0] COND_Z      = 2'd1;
  localparam logic [COND_W-1:0] COND_C      = 2'd2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DECODE = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd3;
  localparam logic [STATE_W-1:0] ST_HALT   = 3'd4;

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decoder for control_unit.
// Ports:
//   opcode_i   instruction opcode field
//   is_alu_o   LDA/ADD/SUB (memory read + accumulator load)
//   is_sta_o   STA (memory write)
//   is_jmp_o   JMP/JZ/JC
//   is_hlt_o   HLT
//   cond_o     jump condition (always / Z / C)
//   alu_op_o   ALU operation for ALU instructions
//   illegal_o  undefined opcode
module cu_decoder
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0]    opcode_i,
  output logic                is_alu_o,
  output logic                is_sta_o,
  output logic                is_jmp_o,
  output logic                is_hlt_o,
  output logic [COND_W-1:0]   cond_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                illegal_o
);

  always_comb begin
    is_alu_o  = 1'b0;
    is_sta_o  = 1'b0;
    is_jmp_o  = 1'b0;
    is_hlt_o  = 1'b0;
    cond_o    = COND_ALWAYS;
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_NOP: ;
      OP_LDA: begin is_alu_o = 1'b1; alu_op_o = ALU_PASS; end
      OP_ADD: begin is_alu_o = 1'b1; alu_op_o = ALU_ADD;  end
      OP_SUB: begin is_alu_o = 1'b1; alu_op_o = ALU_SUB;  end
      OP_STA: is_sta_o = 1'b1;
      OP_JMP: is_jmp_o = 1'b1;
      OP_JZ:  begin is_jmp_o = 1'b1; cond_o = COND_Z; end
      OP_JC:  begin is_jmp_o = 1'b1; cond_o = COND_C; end
      OP_HLT: is_hlt_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the accumulator CPU. Owns PC, IR and
// the latched Z/C flags; drives the memory handshake, ALU op select and
// accumulator write strobe.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   run_i                allow the next fetch
//   mem_req_o/we_o/addr_o  memory request (held until mem_ack_i)
//   mem_ack_i, mem_rdata_i memory completion and read data
//   alu_op_o             ALU op select (EXEC only)
//   alu_fz_i, alu_fc_i   ALU flags
//   acc_we_o             accumulator load strobe
//   pc_o, ir_o, fz_o, fc_o, halted_o, illegal_o  architectural state
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                run_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [ALU_OP_W-1:0] alu_op_o,
  input  logic                alu_fz_i,
  input  logic                alu_fc_i,
  output logic                acc_we_o,
  output logic [ADDR_W-1:0]   pc_o,
  output logic [DATA_W-1:0]   ir_o,
  output logic                fz_o,
  output logic                fc_o,
  output logic                halted_o,
  output logic                illegal_o
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  ir_q, ir_d;
  logic               fz_q, fz_d;
  logic               fc_q, fc_d;
  logic               illegal_q, illegal_d;

  logic                dec_alu, dec_sta, dec_jmp, dec_hlt, dec_illegal;
  logic [COND_W-1:0]   dec_cond;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                jump_taken;

  cu_decoder u_dec (
    .opcode_i  (ir_q[DATA_W-1 -: OPC_W]),
    .is_alu_o  (dec_alu),
    .is_sta_o  (dec_sta),
    .is_jmp_o  (dec_jmp),
    .is_hlt_o  (dec_hlt),
    .cond_o    (dec_cond),
    .alu_op_o  (dec_alu_op),
    .illegal_o (dec_illegal)
  );

  // Jumps test the flags latched by earlier instructions.
  always_comb begin
    jump_taken = 1'b0;
    case (dec_cond)
      COND_ALWAYS: jump_taken = 1'b1;
      COND_Z:      jump_taken = fz_q;
      COND_C:      jump_taken = fc_q;
      default:     jump_taken = 1'b0;
    endcase
  end

  // Next-state and handshake/strobe outputs; all of them are gated by the
  // state register so an async reset drops them immediately.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    fz_d       = fz_q;
    fc_d       = fc_q;
    illegal_d  = illegal_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = pc_q;
    alu_op_o   = ALU_ADD;
    acc_we_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          ir_d    = mem_rdata_i;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else if (dec_hlt) begin
          state_d = ST_HALT;
        end else if (dec_alu || dec_sta) begin
          state_d = ST_EXEC;
        end else begin
          if (dec_jmp && jump_taken) pc_d = ir_q[ADDR_W-1:0];
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        mem_req_o  = 1'b1;
        mem_we_o   = dec_sta;
        mem_addr_o = ir_q[ADDR_W-1:0];
        if (dec_alu) alu_op_o = dec_alu_op;
        if (mem_ack_i) begin
          if (dec_alu) begin
            acc_we_o = 1'b1;
            fz_d     = alu_fz_i;
            fc_d     = alu_fc_i;
          end
          state_d = ST_IDLE;
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      fz_q      <= 1'b0;
      fc_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      fz_q      <= fz_d;
      fc_q      <= fc_d;
      illegal_q <= illegal_d;
    end
  end

  assign pc_o      = pc_q;
  assign ir_o      = ir_q;
  assign fz_o      = fz_q;
  assign fc_o      = fc_q;
  assign halted_o  = (state_q == ST_HALT);
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit with a memory, ALU and
// accumulator model around it.
module tb_control_unit;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              run_i;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [2:0]        alu_op;
  logic              alu_fz, alu_fc, acc_we;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic              fz, fc, halted, illegal;

  logic [DATA_W-1:0] mem [16];
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] alu_res;
  int                wait_n;
  int                wcnt;
  int                checks = 0;
  int                errors = 0;

  // stability monitor state
  logic              pend;
  logic              p_req, p_we;
  logic [ADDR_W-1:0] p_addr, p_pc;
  logic [DATA_W-1:0] p_ir;
  logic              stab_bad;
  int                waits_seen;

  always #5 clk = ~clk;

  control_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .run_i       (run_i),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .alu_op_o    (alu_op),
    .alu_fz_i    (alu_fz),
    .alu_fc_i    (alu_fc),
    .acc_we_o    (acc_we),
    .pc_o        (pc),
    .ir_o        (ir),
    .fz_o        (fz),
    .fc_o        (fc),
    .halted_o    (halted),
    .illegal_o   (illegal)
  );

  // Memory with a programmable number of wait states before ack.
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (wcnt == wait_n);

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) wcnt <= 0;
    else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (rst_ni && mem_req && mem_ack && mem_we) mem[mem_addr] = acc;
  end

  // ALU + accumulator model.
  always_comb begin
    logic [DATA_W:0] wide;
    wide = '0;
    case (alu_op)
      3'b000:  wide = {1'b0, acc} + {1'b0, mem_rdata};
      3'b001:  wide = {1'b0, acc} - {1'b0, mem_rdata};
      default: wide = {1'b0, mem_rdata};
    endcase
    alu_res = wide[DATA_W-1:0];
    alu_fc  = wide[DATA_W];
    alu_fz  = (wide[DATA_W-1:0] == '0);
  end

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) acc <= '0;
    else if (acc_we) acc <= alu_res;
  end

  always @(negedge clk) begin
    if (!rst_ni) begin
      pend = 1'b0;
    end else begin
      if (pend && (mem_req !== p_req || mem_we !== p_we || mem_addr !== p_addr ||
                   pc !== p_pc || ir !== p_ir))
        stab_bad = 1'b1;
      pend = mem_req && !mem_ack;
      if (pend) waits_seen = waits_seen + 1;
    end
    p_req = mem_req; p_we = mem_we; p_addr = mem_addr; p_pc = pc; p_ir = ir;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int wn);
    rst_ni = 1'b0;
    run_i  = 1'b0;
    wait_n = wn;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  // Single-step one instruction: pulse run_i for one cycle, then let it finish.
  task automatic step();
    @(negedge clk);
    run_i = 1'b1;
    @(negedge clk);
    run_i = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic run_to_halt(output int cyc);
    @(negedge clk);
    run_i = 1'b1;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (halted) break;
    end
    run_i = 1'b0;
  endtask

  task automatic load_prog2();
    mem[0] = 8'h15; mem[1] = 8'h26; mem[2] = 8'h47; mem[3] = 8'hF0;
    mem[5] = 8'hF0; mem[6] = 8'h20;
  endtask

  initial begin
    int  cyc;
    logic seen;
    stab_bad = 1'b0; waits_seen = 0; pend = 1'b0;
    rst_ni = 1'b0; run_i = 1'b0; wait_n = 0;

    // 1: reset asserted mid-FETCH with ack arriving the same cycle
    do_reset(0);
    load_prog2();
    run_i = 1'b1;
    @(posedge clk); #1;
    chk("fetch_req", 32'(mem_req), 32'd1);
    rst_ni = 1'b0; #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_accwe", 32'(acc_we), 32'd0);
    chk("rst_aluop", 32'(alu_op), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_flags", {30'd0, fz, fc}, 32'd0);
    chk("rst_halt_ill", {30'd0, halted, illegal}, 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_pc", 32'(pc), 32'd0);

    // 2: LDA 5; ADD 6; STA 7; HLT, zero-wait
    do_reset(0);
    load_prog2();
    run_to_halt(cyc);
    chk("p2_cycles", 32'(cyc), 32'd15);
    chk("p2_mem7", 32'(mem[7]), 32'h10);
    chk("p2_fc", 32'(fc), 32'd1);
    chk("p2_fz", 32'(fz), 32'd0);
    chk("p2_pc", 32'(pc), 32'd4);
    chk("p2_ir", 32'(ir), 32'hF0);
    chk("p2_halt_noreq", 32'(mem_req), 32'd0);
    chk("p2_illegal", 32'(illegal), 32'd0);

    // 3: flags from SUB, JC falls through, JZ taken
    do_reset(0);
    mem[0] = 8'h18; mem[1] = 8'h38; mem[2] = 8'h7A; mem[3] = 8'h6C; mem[8] = 8'h01;
    step();
    chk("p3_lda_pc", 32'(pc), 32'd1);
    chk("p3_lda_flags", {30'd0, fz, fc}, 32'd0);
    chk("p3_idle_aluop", 32'(alu_op), 32'd0);
    step();
    chk("p3_sub_fz", 32'(fz), 32'd1);
    chk("p3_sub_fc", 32'(fc), 32'd0);
    step();
    chk("p3_jc_pc", 32'(pc), 32'd3);
    step();
    chk("p3_jz_pc", 32'(pc), 32'hC);

    // 4: program 2 with 3 wait states on every access
    do_reset(3);
    load_prog2();
    stab_bad = 1'b0; waits_seen = 0;
    run_to_halt(cyc);
    chk("p4_cycles", 32'(cyc), 32'd36);
    chk("p4_mem7", 32'(mem[7]), 32'h10);
    chk("p4_flags", {30'd0, fz, fc}, 32'd1);
    chk("p4_stable", 32'(stab_bad), 32'd0);
    chk("p4_waits", 32'(waits_seen), 32'd21);

    // 5: PC wraps from 0xF to 0x0
    do_reset(0);
    mem[0] = 8'h5F; mem[15] = 8'h00;
    step();
    chk("p5_jmp_pc", 32'(pc), 32'hF);
    step();
    chk("p5_wrap_pc", 32'(pc), 32'h0);

    // 6: illegal opcode halts with no further requests
    do_reset(0);
    mem[0] = 8'h80;
    step();
    chk("p6_illegal", 32'(illegal), 32'd1);
    chk("p6_halted", 32'(halted), 32'd1);
    chk("p6_pc", 32'(pc), 32'd1);
    seen = 1'b0;
    run_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    run_i = 1'b0;
    chk("p6_noreq", 32'(seen), 32'd0);

    // 7: run_i dropped during EXEC
    do_reset(2);
    mem[0] = 8'h15; mem[1] = 8'h00; mem[5] = 8'hF0;
    run_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 4'd5) begin seen = 1'b1; break; end
    end
    chk("p7_exec_seen", 32'(seen), 32'd1);
    run_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 3 && mem_req) seen = 1'b1;
    end
    chk("p7_acc", 32'(acc), 32'hF0);
    chk("p7_pc", 32'(pc), 32'd1);
    chk("p7_parked", 32'(seen), 32'd0);
    run_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 4'd1) begin seen = 1'b1; break; end
    end
    run_i = 1'b0;
    chk("p7_resume_fetch", 32'(seen), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
